// File: rtl/poly_op_ctrl.sv
// Command sequencer for the polynomial address generator and butterfly datapath:
// a 2-deep command FIFO feeding one RUN/DRAIN/DONE operation at a time.
module poly_op_ctrl #(
  parameter int NTT_CYCLES    = 224,
  parameter int INTT_CYCLES   = 224,
  parameter int MULT_CYCLES   = 64,
  parameter int ADDSUB_CYCLES = 32,
  parameter int PIPE_LAT      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_mode,
  output logic       cmd_ready,
  input  logic       abort,
  output logic [1:0] mode,
  output logic [7:0] clk_counter,
  output logic [2:0] layer,
  output logic       rd_en,
  output logic       wr_en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state;
  logic [1:0]          fifo_mem [2];
  logic                fifo_wr_ptr;
  logic                fifo_rd_ptr;
  logic [1:0]          fifo_cnt;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic [7:0]          last_step;
  logic [2:0]          drain_cnt;
  logic [PIPE_LAT-1:0] wr_pipe;

  assign fifo_empty = (fifo_cnt == 2'd0);
  // No bypass: a full FIFO refuses a push even in a cycle where it also pops.
  assign cmd_ready  = (fifo_cnt != 2'd2);
  assign push       = cmd_valid && cmd_ready && !abort;
  assign pop        = !abort && !fifo_empty && (state == IDLE || state == DONE);
  assign busy       = (state != IDLE);
  assign layer      = clk_counter[7:5];
  assign wr_en      = wr_pipe[PIPE_LAT-1];

  // NOTE: last_step is given a value before the case so no latch is inferred.
  always_comb begin
    last_step = 8'(NTT_CYCLES - 1);
    case (mode)
      2'd1:    last_step = 8'(INTT_CYCLES - 1);
      2'd2:    last_step = 8'(MULT_CYCLES - 1);
      2'd3:    last_step = 8'(ADDSUB_CYCLES - 1);
      default: last_step = 8'(NTT_CYCLES - 1);
    endcase
  end

  // NOTE: the two storage words are reset too, so an X can never be popped into mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_mem[0] <= 2'd0;
      fifo_mem[1] <= 2'd0;
      fifo_wr_ptr <= 1'b0;
      fifo_rd_ptr <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else if (abort) begin
      fifo_wr_ptr <= 1'b0;
      fifo_rd_ptr <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (push) begin
        fifo_mem[fifo_wr_ptr] <= cmd_mode;
        fifo_wr_ptr           <= ~fifo_wr_ptr;
      end
      if (pop) fifo_rd_ptr <= ~fifo_rd_ptr;
      fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      mode        <= 2'd0;
      clk_counter <= 8'd0;
      rd_en       <= 1'b0;
      done        <= 1'b0;
      drain_cnt   <= 3'd0;
    end else if (abort) begin
      // mode is deliberately left alone so addr_gen keeps a stable selection.
      state       <= IDLE;
      clk_counter <= 8'd0;
      rd_en       <= 1'b0;
      done        <= 1'b0;
      drain_cnt   <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (pop) begin
            mode        <= fifo_mem[fifo_rd_ptr];
            clk_counter <= 8'd0;
            rd_en       <= 1'b1;
            state       <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (clk_counter == last_step) begin
            clk_counter <= 8'd0;
            rd_en       <= 1'b0;
            drain_cnt   <= 3'd0;
            state       <= DRAIN;
          end else begin
            clk_counter <= clk_counter + 8'd1;
          end
        end
        DRAIN: begin
          if (drain_cnt == 3'(PIPE_LAT - 1)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write-back enable is the read enable seen PIPE_LAT cycles later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_pipe <= '0;
    end else if (abort) begin
      wr_pipe <= '0;
    end else begin
      wr_pipe <= PIPE_LAT'({wr_pipe, rd_en});
    end
  end

endmodule

// File: tb/tb_poly_op_ctrl.sv
// Randomised bench for poly_op_ctrl: two builds (PIPE_LAT 4 and 1) share stimulus and are
// compared every cycle against a timeline model of queued operations.
module tb_poly_op_ctrl;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       abort     = 1'b0;
  logic [1:0] cmd_mode  = 2'd0;

  logic [1:0]      o_ready;
  logic [1:0][1:0] o_mode;
  logic [1:0][7:0] o_cnt;
  logic [1:0][2:0] o_layer;
  logic [1:0]      o_rd;
  logic [1:0]      o_wr;
  logic [1:0]      o_busy;
  logic [1:0]      o_done;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Model: per build, queued commands, the active op and cycles elapsed since its RUN start.
  logic [1:0] m_qd   [2][2];
  int         m_qn   [2];
  bit         m_act  [2];
  int         m_t    [2];
  logic [1:0] m_mode [2];

  always #5 clk = ~clk;

  poly_op_ctrl #(.PIPE_LAT(4)) dut_lat4 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_mode(cmd_mode),
    .cmd_ready(o_ready[0]), .abort(abort), .mode(o_mode[0]), .clk_counter(o_cnt[0]),
    .layer(o_layer[0]), .rd_en(o_rd[0]), .wr_en(o_wr[0]), .busy(o_busy[0]), .done(o_done[0])
  );

  poly_op_ctrl #(.PIPE_LAT(1)) dut_lat1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_mode(cmd_mode),
    .cmd_ready(o_ready[1]), .abort(abort), .mode(o_mode[1]), .clk_counter(o_cnt[1]),
    .layer(o_layer[1]), .rd_en(o_rd[1]), .wr_en(o_wr[1]), .busy(o_busy[1]), .done(o_done[1])
  );

  function automatic int n_of(input logic [1:0] m);
    case (m)
      2'd0:    return 224;
      2'd1:    return 224;
      2'd2:    return 64;
      default: return 32;
    endcase
  endfunction

  function automatic int pl(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_qn[k]   = 0;
      m_act[k]  = 1'b0;
      m_t[k]    = 0;
      m_mode[k] = 2'd0;
    end
  endtask

  // Advance the model by one rising edge using the inputs applied before that edge.
  task automatic model_edge(input bit v, input logic [1:0] m, input bit ab);
    for (int k = 0; k < 2; k++) begin
      bit acc, pop_ok, have;
      if (ab) begin
        m_act[k] = 1'b0;
        m_qn[k]  = 0;
      end else begin
        acc    = v && (m_qn[k] < 2);
        pop_ok = !m_act[k] || (m_t[k] == n_of(m_mode[k]) + pl(k));
        have   = (m_qn[k] > 0);
        if (m_act[k]) begin
          m_t[k]++;
          if (m_t[k] > n_of(m_mode[k]) + pl(k)) m_act[k] = 1'b0;
        end
        if (pop_ok && have) begin
          m_mode[k]  = m_qd[k][0];
          m_qd[k][0] = m_qd[k][1];
          m_qn[k]--;
          m_act[k]   = 1'b1;
          m_t[k]     = 0;
        end
        if (acc) begin
          m_qd[k][m_qn[k]] = m;
          m_qn[k]++;
        end
      end
    end
  endtask

  task automatic compare_all(input string phase);
    for (int k = 0; k < 2; k++) begin
      int n, t, e_cnt;
      bit a, e_rd, e_wr, e_done;
      string p;
      n      = n_of(m_mode[k]);
      t      = m_t[k];
      a      = m_act[k];
      e_rd   = a && (t < n);
      e_cnt  = e_rd ? t : 0;
      e_wr   = a && (t >= pl(k)) && (t < n + pl(k));
      e_done = a && (t == n + pl(k));
      p = $sformatf("c%0d %s lat%0d", cyc, phase, pl(k));
      check({p, " cmd_ready"},   32'(o_ready[k]), 32'(m_qn[k] < 2));
      check({p, " mode"},        32'(o_mode[k]),  32'(m_mode[k]));
      check({p, " clk_counter"}, 32'(o_cnt[k]),   e_cnt);
      check({p, " layer"},       32'(o_layer[k]), e_cnt / 32);
      check({p, " rd_en"},       32'(o_rd[k]),    32'(e_rd));
      check({p, " wr_en"},       32'(o_wr[k]),    32'(e_wr));
      check({p, " busy"},        32'(o_busy[k]),  32'(a));
      check({p, " done"},        32'(o_done[k]),  32'(e_done));
    end
  endtask

  // Inputs change at the falling edge; outputs are compared at the next falling edge.
  task automatic step(input bit v, input logic [1:0] m, input bit ab, input string phase);
    cmd_valid = v;
    cmd_mode  = m;
    abort     = ab;
    @(posedge clk);
    model_edge(v, m, ab);
    @(negedge clk);
    cyc++;
    compare_all(phase);
  endtask

  task automatic run_idle(input int budget, input string phase);
    int i;
    i = 0;
    while ((m_act[0] || m_act[1] || m_qn[0] > 0 || m_qn[1] > 0) && i < budget) begin
      step(1'b0, 2'd0, 1'b0, phase);
      i++;
    end
    check({phase, " idle_within_budget"}, 32'(i < budget), 32'd1);
  endtask

  // Reset is dropped mid-cycle; outputs must already show reset values before any edge.
  task automatic async_reset(input string phase);
    #2 rst = 1'b0;
    #1 model_reset();
    compare_all(phase);
    repeat (2) @(negedge clk);
    compare_all({phase, "_hold"});
    rst = 1'b1;
  endtask

  initial begin
    int i;
    model_reset();
    async_reset("reset");

    // Single NTT end to end.
    step(1'b1, 2'd0, 1'b0, "ntt");
    run_idle(1000, "ntt");

    // MULT, ADDSUB, INTT on consecutive cycles.
    step(1'b1, 2'd2, 1'b0, "burst");
    step(1'b1, 2'd3, 1'b0, "burst");
    step(1'b1, 2'd1, 1'b0, "burst");
    run_idle(2000, "burst");

    // NTT running while cmd_valid is held so the FIFO fills and stalls.
    step(1'b1, 2'd0, 1'b0, "full");
    for (int j = 0; j < 300; j++) step(1'b1, 2'd2, 1'b0, "full");
    run_idle(2000, "full");

    // Abort at clk_counter 100 of an NTT with a MULT queued, plus a same-cycle push.
    step(1'b1, 2'd0, 1'b0, "abort");
    step(1'b1, 2'd2, 1'b0, "abort");
    i = 0;
    while (!(m_act[0] && m_t[0] == 100) && i < 400) begin
      step(1'b0, 2'd0, 1'b0, "abort");
      i++;
    end
    check("abort reached_count_100", 32'(i < 400), 32'd1);
    step(1'b1, 2'd3, 1'b1, "abort");
    for (int j = 0; j < 10; j++) step(1'b0, 2'd0, 1'b0, "post_abort");
    run_idle(500, "post_abort");

    // Asynchronous reset in the middle of an ADDSUB drain, then a clean ADDSUB.
    step(1'b1, 2'd3, 1'b0, "drain_rst");
    i = 0;
    while (!(m_act[0] && m_t[0] == 34) && i < 100) begin
      step(1'b0, 2'd0, 1'b0, "drain_rst");
      i++;
    end
    check("drain_rst reached_drain", 32'(i < 100), 32'd1);
    async_reset("drain_rst");
    step(1'b1, 2'd3, 1'b0, "after_rst");
    run_idle(200, "after_rst");

    // Random traffic with occasional aborts.
    for (int j = 0; j < 4000; j++) begin
      step(($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 299) == 0), "rand");
    end
    run_idle(4000, "rand_tail");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
